// File: rtl/isw_dup_fault_check_if.sv
// Bundle of the fault-check stage: both multiplier copies' result shares plus the released
// result, fault flag, sticky alarm and fault counter.
interface isw_dup_fault_check_if #(
   parameter int SHARES = 2,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic [SHARES-1:0] res0_in;
   logic [SHARES-1:0] res1_in;
   logic [SHARES-1:0] rand_in;
   logic              alarm_clr;
   logic              out_valid;
   logic [SHARES-1:0] out_shares;
   logic              out_fault;
   logic              alarm;
   logic [CNT_W-1:0]  fault_cnt;

   modport master (
      output in_valid, res0_in, res1_in, rand_in, alarm_clr,
      input  out_valid, out_shares, out_fault, alarm, fault_cnt
   );

   modport slave (
      input  in_valid, res0_in, res1_in, rand_in, alarm_clr,
      output out_valid, out_shares, out_fault, alarm, fault_cnt
   );
endinterface

// File: rtl/isw_dup_fault_check.sv
// Fault check for the duplicated ISW multiplier pair. A valid pipe tracks the multiplier
// latency; at the tap the two copies' result shares are compared and the result is released
// only if they agree. Mismatches raise a sticky alarm, bump a saturating counter and, once the
// counter reaches LOCK_TH, lock the stage until reset.
// Optional feature macro: DUP_INFECT_EN -- suppressed releases carry rand_in instead of zeros.
//
// state  | meaning
// -------+-------------------------------------------------------------
// OK     | no unacknowledged fault, results released when copies agree
// ALARM  | fault seen, alarm held until alarm_clr without a new fault
// LOCKED | fault threshold reached, every release suppressed until reset
module isw_dup_fault_check #(
   parameter int SHARES  = 2,
   parameter int LAT     = 3,
   parameter int CNT_W   = 8,
   parameter int LOCK_TH = 4
) (
   input logic                  clk,
   input logic                  reset,
   isw_dup_fault_check_if.slave bus
);

   typedef enum logic [1:0] {
      ST_OK     = 2'd0,
      ST_ALARM  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_TH);

   state_t            state;
   state_t            state_nxt;
   logic [LAT-1:0]    vld_pipe;
   logic              vld_t;
   logic              mis;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              rel_valid;
   logic [SHARES-1:0] rel_shares;
   logic              rel_fault;
   logic              out_valid_q;
   logic [SHARES-1:0] out_shares_q;
   logic              out_fault_q;

   // The tap is gated first so X on the result shares outside a tap cannot reach the compare.
   assign vld_t = vld_pipe[LAT-1];
   assign mis   = vld_t & (|(bus.res0_in ^ bus.res1_in));

   // Valid pipe: one stage per multiplier cycle, flushed by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= bus.in_valid;
         for (int i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // Saturating fault counter next value.
   always_comb begin
      cnt_nxt = cnt;
      if (mis && (cnt != CNT_MAX)) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // State register together with the counter that drives the lock decision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_OK;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: a new fault beats alarm_clr, and reaching the threshold beats ALARM.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_OK:     if (mis) state_nxt = ST_ALARM;
         ST_ALARM:  if (bus.alarm_clr && !mis) state_nxt = ST_OK;
         ST_LOCKED: state_nxt = ST_LOCKED;
         default:   state_nxt = ST_LOCKED;
      endcase
      if ((state != ST_LOCKED) && (cnt_nxt == LOCK_VAL)) begin
         state_nxt = ST_LOCKED;
      end
   end

   // Release decision: pass copy 0 only when the copies agree and the stage is not locked.
   always_comb begin
      rel_valid  = vld_t;
      rel_shares = '0;
      rel_fault  = 1'b0;
      if (vld_t) begin
         if (mis || (state == ST_LOCKED)) begin
            rel_fault = 1'b1;
`ifdef DUP_INFECT_EN
            rel_shares = bus.rand_in;
`else
            rel_shares = '0;
`endif
         end else begin
            rel_shares = bus.res0_in;
         end
      end
   end

`ifndef DUP_INFECT_EN
   logic unused_rand;
   assign unused_rand = ^bus.rand_in;
`endif

   // Registered release outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_shares_q <= '0;
         out_fault_q  <= 1'b0;
      end else begin
         out_valid_q  <= rel_valid;
         out_shares_q <= rel_shares;
         out_fault_q  <= rel_fault;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_shares = out_shares_q;
   assign bus.out_fault  = out_fault_q;
   assign bus.alarm      = (state != ST_OK);
   assign bus.fault_cnt  = cnt;

endmodule

// File: tb/tb_isw_dup_fault_check.sv
module tb_isw_dup_fault_check;

   localparam int LAT     = 3;
   localparam int LOCK_TH = 4;
   localparam int CNT_MAX = 255;

   typedef struct packed {
      logic       v;
      logic [1:0] sh;
      logic       f;
      logic       a;
      logic [7:0] cnt;
   } obs_t;

   typedef struct packed {
      logic       v;
      logic [1:0] r0;
      logic [1:0] r1;
      logic       clr;
      logic       rst;
      logic       xres;
   } stim_t;

   logic clk;
   logic reset;

   isw_dup_fault_check_if #(.SHARES(2), .CNT_W(8)) bus ();

   isw_dup_fault_check #(.SHARES(2), .LAT(LAT), .CNT_W(8), .LOCK_TH(LOCK_TH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   int    pipe_q[$];
   stim_t stim_q[$];
   int    m_cnt    = 0;
   bit    m_alarm  = 0;
   bit    m_locked = 0;
   obs_t  m_out    = '0;

   // Transaction: operands at offset 0, result shares at offset LAT, X on the shares between.
   task automatic push_txn(input logic [1:0] r0, input logic [1:0] r1, input logic clr);
      stim_q.push_back('{1'b1, 2'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b1});
      for (int i = 1; i < LAT; i++) stim_q.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1});
      stim_q.push_back('{1'b0, r0, r1, clr, 1'b0, 1'b0});
   endtask

   task automatic push_idle(input int n, input logic clr, input logic rst);
      for (int i = 0; i < n; i++) stim_q.push_back('{1'b0, 2'($urandom), 2'($urandom), clr, rst, 1'b0});
   endtask

   // Drives one cycle and advances the reference model; returns what the DUT shows one edge later.
   task automatic apply(input stim_t s, output obs_t got, output obs_t expv);
      bit         tap;
      bit         sup;
      logic [1:0] rnd;
      tap = (pipe_q.size() > 0) && (pipe_q[0] == cyc - LAT);
      rnd = 2'($urandom);
      bus.in_valid  = s.v;
      bus.res0_in   = (s.xres && !tap) ? 2'bxx : s.r0;
      bus.res1_in   = (s.xres && !tap) ? 2'bxx : s.r1;
      bus.rand_in   = rnd;
      bus.alarm_clr = s.clr;
      reset         = ~s.rst;
      if (s.rst) begin
         pipe_q.delete();
         m_cnt = 0; m_alarm = 0; m_locked = 0; m_out = '0;
      end else begin
         m_out.v = tap; m_out.sh = 2'b00; m_out.f = 1'b0;
         if (tap) begin
            void'(pipe_q.pop_front());
            sup = (s.r0 != s.r1) || m_locked;
            m_out.f = sup;
`ifdef DUP_INFECT_EN
            m_out.sh = sup ? rnd : s.r0;
`else
            m_out.sh = sup ? 2'b00 : s.r0;
`endif
         end
         if (tap && (s.r0 != s.r1)) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_alarm = 1;
            if (m_cnt == LOCK_TH) m_locked = 1;
         end else if (s.clr) begin
            m_alarm = 0;
         end
         if (s.v) pipe_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      m_out.a   = m_alarm || m_locked;
      m_out.cnt = 8'(m_cnt);
      expv = m_out;
      got  = {bus.out_valid, bus.out_shares, bus.out_fault, bus.alarm, bus.fault_cnt};
   endtask

   task automatic test_reset();
      obs_t got, expv;
      push_idle(2, 1'b0, 1'b1);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL reset cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         n_checks++;
         if (got !== 13'h0) $display("FAIL reset_zero cyc=%0d got=%h want=0", cyc, got); else n_pass++;
      end
   endtask

   task automatic test_release();
      obs_t got, expv;
      obs_t obs[$];
      push_txn(2'b10, 2'b10, 1'b0);
      push_idle(1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL release cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         obs.push_back(got);
      end
      n_checks++;
      if (obs[LAT] !== {1'b1, 2'b10, 1'b0, 1'b0, 8'd0}) $display("FAIL release_at_4 got=%h want=%h", obs[LAT], {1'b1, 2'b10, 1'b0, 1'b0, 8'd0}); else n_pass++;
      n_checks++;
      if (obs[LAT-1].v !== 1'b0) $display("FAIL release_early got=%b want=0", obs[LAT-1].v); else n_pass++;
   endtask

   task automatic test_mismatch();
      obs_t got, expv;
      obs_t obs[$];
      push_txn(2'b01, 2'b11, 1'b0);
      push_txn(2'b01, 2'b01, 1'b0);
      push_idle(1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL mismatch cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         obs.push_back(got);
      end
      n_checks++;
      if ({obs[3].v, obs[3].f, obs[3].a, obs[3].cnt} !== {3'b111, 8'd1}) $display("FAIL mismatch_flags got=%h want=%h", {obs[3].v, obs[3].f, obs[3].a, obs[3].cnt}, {3'b111, 8'd1}); else n_pass++;
`ifndef DUP_INFECT_EN
      n_checks++;
      if (obs[3].sh !== 2'b00) $display("FAIL mismatch_suppress got=%b want=00", obs[3].sh); else n_pass++;
`endif
      n_checks++;
      if ({obs[7].v, obs[7].sh, obs[7].f, obs[7].a} !== 5'b10101) $display("FAIL mismatch_next got=%b want=10101", {obs[7].v, obs[7].sh, obs[7].f, obs[7].a}); else n_pass++;
   endtask

   task automatic test_clr_collision();
      obs_t got, expv;
      obs_t obs[$];
      push_txn(2'b10, 2'b01, 1'b1);
      push_idle(1, 1'b1, 1'b0);
      push_idle(1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL clr_collision cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         obs.push_back(got);
      end
      n_checks++;
      if ({obs[3].a, obs[3].cnt} !== {1'b1, 8'd2}) $display("FAIL clr_fault_wins got=%h want=%h", {obs[3].a, obs[3].cnt}, {1'b1, 8'd2}); else n_pass++;
      n_checks++;
      if (obs[4].a !== 1'b0) $display("FAIL clr_alone got=%b want=0", obs[4].a); else n_pass++;
   endtask

   task automatic test_lock();
      obs_t got, expv;
      obs_t obs[$];
      push_txn(2'b00, 2'b11, 1'b0);
      push_txn(2'b11, 2'b10, 1'b0);
      push_txn(2'b11, 2'b11, 1'b1);
      push_idle(1, 1'b1, 1'b0);
      push_idle(1, 1'b0, 1'b1);
      push_idle(1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL lock cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         obs.push_back(got);
      end
      n_checks++;
      if ({obs[7].a, obs[7].cnt} !== {1'b1, 8'd4}) $display("FAIL lock_cnt got=%h want=%h", {obs[7].a, obs[7].cnt}, {1'b1, 8'd4}); else n_pass++;
      n_checks++;
      if ({obs[11].v, obs[11].f} !== 2'b11) $display("FAIL lock_suppress got=%b want=11", {obs[11].v, obs[11].f}); else n_pass++;
`ifndef DUP_INFECT_EN
      n_checks++;
      if (obs[11].sh !== 2'b00) $display("FAIL lock_shares got=%b want=00", obs[11].sh); else n_pass++;
`endif
      n_checks++;
      if (obs[12].a !== 1'b1) $display("FAIL lock_clr_ignored got=%b want=1", obs[12].a); else n_pass++;
      n_checks++;
      if ({obs[14].a, obs[14].cnt} !== 9'd0) $display("FAIL lock_reset got=%h want=0", {obs[14].a, obs[14].cnt}); else n_pass++;
   endtask

   task automatic test_flush();
      obs_t got, expv;
      obs_t obs[$];
      int   nv;
      stim_q.push_back('{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
      push_idle(1, 1'b0, 1'b0);
      push_idle(1, 1'b0, 1'b1);
      stim_q.push_back('{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0});
      push_idle(6, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) stim_q.push_back('{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) stim_q.push_back('{1'b0, 2'(i + 1), 2'(i + 1), 1'b0, 1'b0, 1'b0});
      push_idle(2, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL flush cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         obs.push_back(got);
      end
      nv = 0;
      for (int k = 0; k < 13; k++) nv += int'(obs[k].v);
      n_checks++;
      if (nv != 0) $display("FAIL flush_no_valid got=%0d want=0", nv); else n_pass++;
      n_checks++;
      if ({obs[13].v, obs[14].v, obs[15].v, obs[16].v} !== 4'b1110) $display("FAIL flush_b2b got=%b want=1110", {obs[13].v, obs[14].v, obs[15].v, obs[16].v}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      obs_t       got, expv;
      int         nv;
      logic [1:0] r;
      nv = 0;
      push_idle(1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         r = 2'($urandom);
         stim_q.push_back('{1'b1, r, r, 1'b0, 1'b0, 1'b0});
      end
      push_idle(LAT + 1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
         nv += int'(got.v);
      end
      n_checks++;
      if (nv != 20) $display("FAIL back_to_back_count got=%0d want=20", nv); else n_pass++;
   endtask

   task automatic test_random();
      obs_t got, expv;
      stim_t s;
      logic [1:0] r;
      push_idle(1, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         r      = 2'($urandom);
         s.v    = 1'($urandom_range(0, 1));
         s.r0   = r;
         s.r1   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : r;
         s.clr  = ($urandom_range(0, 3) == 0);
         s.rst  = ($urandom_range(0, 49) == 0);
         s.xres = 1'($urandom_range(0, 1));
         stim_q.push_back(s);
      end
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
      end
   endtask

   task automatic test_saturate();
      obs_t got, expv;
      push_idle(1, 1'b0, 1'b1);
      for (int i = 0; i < 262; i++) stim_q.push_back('{1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0});
      push_idle(LAT + 1, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         apply(stim_q.pop_front(), got, expv);
         n_checks++;
         if (got !== expv) $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, got, expv); else n_pass++;
      end
      n_checks++;
      if (got.cnt !== 8'hFF) $display("FAIL saturate_max got=%h want=ff", got.cnt); else n_pass++;
   endtask

   initial begin
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.res0_in   = 2'b00;
      bus.res1_in   = 2'b00;
      bus.rand_in   = 2'b00;
      bus.alarm_clr = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_release();
      test_mismatch();
      test_clr_collision();
      test_lock();
      test_flush();
      test_back_to_back();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
